// File: rtl/greenhouse_readout_buffer.sv
// greenhouse_readout_buffer
// Accepts binary sensor readings over valid/ready, converts each one to BCD
// with a bit-serial shift-add-3 engine, and stages the result in a pending
// bank. The display bank is refreshed from the pending bank only on
// frame_start, so the renderer never sees a digit change mid-frame.
module greenhouse_readout_buffer #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 10,
   parameter int DIGITS = 3,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         CLOCK_50,
   input  logic                         RESET_N,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CH_W-1:0]              in_channel,
   input  logic [DATA_W-1:0]            in_value,
   input  logic                         frame_start,
   output logic [NUM_CH*DIGITS*4-1:0]   disp_bcd,
   output logic [NUM_CH-1:0]            disp_valid,
   output logic [NUM_CH-1:0]            disp_over
);

   // 10^n, used to derive the largest displayable value
   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) begin
         r = r * 10;
      end
      return r;
   endfunction

   localparam int BCD_W   = DIGITS * 4;
   localparam int SH_W    = BCD_W + DATA_W;
   localparam int CNT_W   = $clog2(DATA_W + 1);
   localparam int MAX_VAL = pow10(DIGITS) - 1;

   // One double-dabble iteration: correct digits >= 5, then shift left by one
   function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] s);
      logic [SH_W-1:0] t;
      t = s;
      for (int d = 0; d < DIGITS; d++) begin
         if (t[DATA_W + 4*d +: 4] >= 4'd5) begin
            t[DATA_W + 4*d +: 4] = t[DATA_W + 4*d +: 4] + 4'd3;
         end else begin
            t[DATA_W + 4*d +: 4] = t[DATA_W + 4*d +: 4];
         end
      end
      return {t[SH_W-2:0], 1'b0};
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_WRITE   = 2'd2
   } state_t;

   state_t                    state_r;
   logic                      ready_r;
   logic [CNT_W-1:0]          cnt_r;
   logic [SH_W-1:0]           sh_r;
   logic [CH_W-1:0]           ch_r;
   logic                      over_r;

   logic [NUM_CH*BCD_W-1:0]   pend_bcd_r;
   logic [NUM_CH-1:0]         pend_over_r;
   logic [NUM_CH-1:0]         dirty_r;

   logic [DATA_W-1:0]         clamp_val_s;
   logic                      clamp_over_s;
   logic [SH_W-1:0]           step_s;
   logic                      wr_en_s;

   assign in_ready = ready_r;

   // Saturate readings that cannot be shown in DIGITS decimal digits
   always_comb begin
      if (32'(in_value) > 32'(MAX_VAL)) begin
         clamp_val_s  = DATA_W'(MAX_VAL);
         clamp_over_s = 1'b1;
      end else begin
         clamp_val_s  = in_value;
         clamp_over_s = 1'b0;
      end
   end

   // Next value of the conversion shift register and write strobe
   always_comb begin
      step_s  = dabble_step(sh_r);
      wr_en_s = (state_r == ST_WRITE);
   end

   // Handshake / conversion FSM; in_ready is a registered output
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state_r <= ST_IDLE;
         ready_r <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
         sh_r    <= {SH_W{1'b0}};
         ch_r    <= {CH_W{1'b0}};
         over_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid && ready_r) begin
                  ch_r    <= in_channel;
                  over_r  <= clamp_over_s;
                  sh_r    <= {{BCD_W{1'b0}}, clamp_val_s};
                  cnt_r   <= CNT_W'(DATA_W);
                  ready_r <= 1'b0;
                  state_r <= ST_CONVERT;
               end else begin
                  ready_r <= 1'b1;
               end
            end
            ST_CONVERT: begin
               sh_r  <= step_s;
               cnt_r <= cnt_r - CNT_W'(1);
               if (cnt_r == CNT_W'(1)) begin
                  state_r <= ST_WRITE;
               end else begin
                  state_r <= ST_CONVERT;
               end
            end
            ST_WRITE: begin
               ready_r <= 1'b1;
               state_r <= ST_IDLE;
            end
            default: begin
               ready_r <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Pending bank update and frame-synchronous publish to the display bank.
   // Publish reads pre-edge pending/dirty; a same-edge write re-marks dirty.
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         pend_bcd_r  <= {(NUM_CH*BCD_W){1'b0}};
         pend_over_r <= {NUM_CH{1'b0}};
         dirty_r     <= {NUM_CH{1'b0}};
         disp_bcd    <= {(NUM_CH*BCD_W){1'b0}};
         disp_valid  <= {NUM_CH{1'b0}};
         disp_over   <= {NUM_CH{1'b0}};
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (frame_start && dirty_r[c]) begin
               disp_bcd[c*BCD_W +: BCD_W] <= pend_bcd_r[c*BCD_W +: BCD_W];
               disp_over[c]               <= pend_over_r[c];
               disp_valid[c]              <= 1'b1;
               dirty_r[c]                 <= 1'b0;
            end
            if (wr_en_s && (ch_r == CH_W'(c))) begin
               pend_bcd_r[c*BCD_W +: BCD_W] <= sh_r[SH_W-1:DATA_W];
               pend_over_r[c]               <= over_r;
               dirty_r[c]                   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_greenhouse_readout_buffer.sv
// Self-checking bench for greenhouse_readout_buffer: a decimal-arithmetic
// reference model compared every cycle, plus directed literal checks.
module tb_greenhouse_readout_buffer;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 10;
   localparam int DIGITS = 3;
   localparam int MAXV   = 999;

   logic                        CLOCK_50 = 1'b0;
   logic                        RESET_N;
   logic                        in_valid;
   logic                        in_ready;
   logic [1:0]                  in_channel;
   logic [DATA_W-1:0]           in_value;
   logic                        frame_start;
   logic [NUM_CH*DIGITS*4-1:0]  disp_bcd;
   logic [NUM_CH-1:0]           disp_valid;
   logic [NUM_CH-1:0]           disp_over;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // reference model state (plain integers)
   int m_pend  [NUM_CH];
   bit m_pover [NUM_CH];
   bit m_dirty [NUM_CH];
   int m_disp  [NUM_CH];
   bit m_dover [NUM_CH];
   bit m_dvalid[NUM_CH];
   bit m_rdy;
   int m_wait;
   int m_ch;
   int m_val;
   bit m_over;

   greenhouse_readout_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
      .CLOCK_50    (CLOCK_50),
      .RESET_N     (RESET_N),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_channel  (in_channel),
      .in_value    (in_value),
      .frame_start (frame_start),
      .disp_bcd    (disp_bcd),
      .disp_valid  (disp_valid),
      .disp_over   (disp_over)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      logic [3:0] h, t, u;
      h = 4'((v / 100) % 10);
      t = 4'((v / 10) % 10);
      u = 4'(v % 10);
      return {h, t, u};
   endfunction

   function automatic logic [NUM_CH*12-1:0] exp_bus();
      logic [NUM_CH*12-1:0] b;
      b = '0;
      for (int c = 0; c < NUM_CH; c++) b[c*12 +: 12] = to_bcd(m_disp[c]);
      return b;
   endfunction

   function automatic logic [3:0] exp_bits(input int which);
      logic [3:0] b;
      for (int c = 0; c < NUM_CH; c++) b[c] = (which == 0) ? m_dvalid[c] : m_dover[c];
      return b;
   endfunction

   function automatic logic [11:0] chan(input int c);
      return disp_bcd[c*12 +: 12];
   endfunction

   // model: follows the behavioural rules edge by edge
   always @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_pend[c] = 0; m_pover[c] = 0; m_dirty[c] = 0;
            m_disp[c] = 0; m_dover[c] = 0; m_dvalid[c] = 0;
         end
         m_rdy = 0; m_wait = 0;
      end else begin
         if (frame_start) begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (m_dirty[c]) begin
                  m_disp[c] = m_pend[c]; m_dover[c] = m_pover[c];
                  m_dvalid[c] = 1; m_dirty[c] = 0;
               end
            end
         end
         if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
               m_pend[m_ch] = m_val; m_pover[m_ch] = m_over; m_dirty[m_ch] = 1;
               m_rdy = 1;
            end
         end else if (m_rdy && in_valid) begin
            m_ch   = int'(in_channel);
            m_over = (int'(in_value) > MAXV);
            m_val  = m_over ? MAXV : int'(in_value);
            m_rdy  = 0;
            m_wait = DATA_W + 1;
         end else if (!m_rdy) begin
            m_rdy = 1;
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge CLOCK_50) begin
      if (chk_en) begin
         check("in_ready",   {63'd0, in_ready}, {63'd0, m_rdy});
         check("disp_bcd",   {16'd0, disp_bcd}, {16'd0, exp_bus()});
         check("disp_valid", {60'd0, disp_valid}, {60'd0, exp_bits(0)});
         check("disp_over",  {60'd0, disp_over}, {60'd0, exp_bits(1)});
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge CLOCK_50);
         n++;
      end
      check("ready_wait", {63'd0, in_ready}, 64'd1);
   endtask

   task automatic send(input int ch, input int val);
      wait_idle();
      in_valid   = 1'b1;
      in_channel = 2'(ch);
      in_value   = DATA_W'(val);
      @(negedge CLOCK_50);
      in_valid   = 1'b0;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      @(negedge CLOCK_50);
      frame_start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      RESET_N = 1'b0; in_valid = 1'b1; in_channel = 2'd2;
      in_value = 10'd437; frame_start = 1'b0;
      @(posedge CLOCK_50);
      chk_en = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      frame_start = 1'b1;
      @(negedge CLOCK_50);
      frame_start = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      check("rst_ready", {63'd0, in_ready}, 64'd0);
      check("rst_bcd",   {16'd0, disp_bcd}, 64'd0);
      check("rst_valid", {60'd0, disp_valid}, 64'd0);
      check("rst_over",  {60'd0, disp_over}, 64'd0);
      RESET_N = 1'b1; in_valid = 1'b0;
      @(negedge CLOCK_50);
      check("rel_ready", {63'd0, in_ready}, 64'd1);

      // basic conversion
      send(2, 437);
      cnt = 0;
      while (!in_ready && cnt < 100) begin
         cnt++;
         @(negedge CLOCK_50);
      end
      check("busy_cycles", 64'(cnt), 64'd11);
      check("pre_frame_ch2", {52'd0, chan(2)}, 64'd0);
      frame();
      check("basic_ch2",   {52'd0, chan(2)}, 64'h437);
      check("basic_valid", {60'd0, disp_valid}, 64'h4);
      check("basic_over",  {60'd0, disp_over}, 64'h0);

      // saturation and recovery
      send(0, 1023); wait_idle(); frame();
      check("sat_ch0",  {52'd0, chan(0)}, 64'h999);
      check("sat_over", {63'd0, disp_over[0]}, 64'd1);
      send(0, 5); wait_idle(); frame();
      check("small_ch0",  {52'd0, chan(0)}, 64'h005);
      check("small_over", {63'd0, disp_over[0]}, 64'd0);

      // last write wins
      send(1, 123); wait_idle();
      send(1, 456); wait_idle(); frame();
      check("last_ch1", {52'd0, chan(1)}, 64'h456);
      frame();
      check("hold_ch1", {52'd0, chan(1)}, 64'h456);

      // write coinciding with frame_start
      send(0, 250); wait_idle();
      send(3, 999);
      repeat (10) @(negedge CLOCK_50);
      frame();
      check("coll_ch0",    {52'd0, chan(0)}, 64'h250);
      check("coll_ch3",    {52'd0, chan(3)}, 64'h000);
      check("coll_valid3", {63'd0, disp_valid[3]}, 64'd0);
      frame();
      check("next_ch3",    {52'd0, chan(3)}, 64'h999);
      check("next_valid3", {63'd0, disp_valid[3]}, 64'd1);

      // reset during conversion
      send(0, 700);
      repeat (3) @(negedge CLOCK_50);
      RESET_N = 1'b0;
      @(negedge CLOCK_50);
      RESET_N = 1'b1;
      frame();
      check("abort_bcd",   {16'd0, disp_bcd}, 64'd0);
      check("abort_valid", {60'd0, disp_valid}, 64'd0);
      send(0, 700); wait_idle(); frame();
      check("redo_ch0",   {52'd0, chan(0)}, 64'h700);
      check("redo_valid", {60'd0, disp_valid}, 64'h1);

      repeat (2) @(negedge CLOCK_50);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/greenhouse_readout_buffer.md
# greenhouse_readout_buffer

Sensor-to-display staging block for the greenhouse VGA panel. It accepts binary sensor readings over a valid/ready handshake and converts each one to BCD with a sequential shift-add-3 engine. Results are held in a pending bank. The pending bank is published to a display bank only on a frame-start pulse, so the pixel renderer downstream of the 640x480 timing generator never sees a value change mid-frame.

## Interface

Parameters:
- NUM_CH, 4: number of sensor channels/panels (temp, humidity, soil, light).
- DATA_W, 10: binary reading width.
- DIGITS, 3: BCD digits per channel; max displayable value 10^DIGITS-1.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET_N  in  1  reset; one clock; reset is synchronous and active-low.
- in_valid  in  1  reading offered.
- in_ready  out  1  block can accept a reading.
- in_channel  in  clog2(NUM_CH)  target channel.
- in_value  in  DATA_W  unsigned binary reading.
- frame_start  in  1  one-cycle pulse (CLOCK_50 domain) at start of vertical blanking.
- disp_bcd  out  NUM_CH*DIGITS*4  display bank; channel 0 in LSBs, digit 0 (units) lowest nibble per channel.
- disp_valid  out  NUM_CH  bit set once channel has been published at least once.
- disp_over  out  NUM_CH  bit set if the published value was clamped.

## Operation

- FSM states: IDLE, CONVERT, WRITE.
- IDLE:
  - in_ready=1.
  - Handshake occurs when in_valid && in_ready are sampled high on a rising edge.
  - On handshake, the block latches in_channel. It also latches a clamped value: if in_value > 10^DIGITS-1, the value is clamped to 10^DIGITS-1 and the over flag is set; otherwise the flag is clear.
  - The BCD accumulator is cleared, the bit counter is loaded with DATA_W, and the FSM enters CONVERT.
- CONVERT (double-dabble), one bit per cycle:
  - Add 3 to every BCD digit >= 5.
  - Shift {bcd, value} left by 1 (MSB of value enters bcd LSB).
  - Decrement the counter.
  - After DATA_W iterations, go to WRITE.
- WRITE:
  - Store the BCD result and over flag into pending[channel] and set dirty[channel].
  - Return to IDLE.
  - A channel index >= NUM_CH completes the handshake but writes nothing.
- Publish: on any edge with frame_start=1, every channel with dirty=1 has pending copied to disp_bcd/disp_over; its dirty bit is cleared and its disp_valid bit is set. Channels with dirty=0 are untouched.
- Repeated writes to one channel between frames: last value wins.
- Accumulator width DIGITS*4; shift register width DIGITS*4+DATA_W; no carry out of the top digit (guaranteed by the clamp).

## Timing

- Reset (RESET_N low at an edge):
  - state=IDLE, in_ready=0, counter=0.
  - All pending, dirty, disp_bcd, disp_valid and disp_over = 0.
  - in_valid is ignored.
- in_ready is registered. It is 1 from the first edge after RESET_N is sampled high.
- Latency: handshake on edge k. CONVERT shifts on edges k+1..k+DATA_W. WRITE on edge k+DATA_W+1. in_ready is low for DATA_W+1 cycles and high again after edge k+DATA_W+1. Throughput is 1 reading per DATA_W+2 cycles (12 at defaults).
- The display bank changes only on an edge where frame_start=1, and outputs are valid the following cycle.
- Simultaneous WRITE and frame_start on the same edge: publish uses the pending/dirty state from before that edge. The written channel stays dirty and is published at the next frame_start. Other dirty channels publish normally.
- Reset mid-CONVERT/WRITE: the conversion is abandoned and nothing reaches pending or display.
- frame_start during reset is ignored.

## Test plan

- Reset: hold RESET_N low 5 cycles with in_valid=1, frame_start pulsed → in_ready=0, disp_bcd=0, disp_valid=4'b0000, disp_over=0; after release, in_ready=1 on the next cycle.
- Basic conversion: ch2, value 437 → in_ready low exactly 11 cycles; disp_bcd unchanged before frame_start; after frame_start, ch2 nibbles=12'h437, disp_valid=4'b0100, disp_over=0.
- Saturation: ch0, value 1023, frame_start → ch0=12'h999, disp_over[0]=1. Then ch0, value 5, frame_start → ch0=12'h005, disp_over[0]=0.
- Last-wins: ch1=123 then ch1=456, then frame_start → ch1=12'h456. A second frame_start with no new data leaves it unchanged.
- Collision: ch0=250 written and idle, then ch3=999 whose WRITE edge coincides with frame_start → ch0 shows 12'h250, ch3 still 0 and disp_valid[3]=0; at the next frame_start, ch3=12'h999 and disp_valid[3]=1.
- Reset mid-operation: accept ch0=700, assert RESET_N low 4 cycles later for 1 cycle, then frame_start → disp_bcd=0, disp_valid=0; a new ch0=700 afterwards publishes 12'h700 normally.
